// File: rtl/score_ball_compositor.sv
// score_ball_compositor: ball sprite, decimal score and hit statistics
// merged over the camera stream through a 2-stage pixel pipeline.
module score_ball_compositor #(
  parameter int DIGITS         = 3,
  parameter int SCORE_W        = 10,
  parameter int TEXT_X         = 500,
  parameter int TEXT_Y         = 20,
  parameter int SCALE_LOG2     = 0,
  parameter int TEXT_OPAQUE    = 1,
  parameter int BALL_SIZE      = 20,
  parameter int OFS_W          = 5,
  parameter int HIT_RED_MIN    = 20,
  parameter int HIT_MIN_PIXELS = 40
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic               de,
  input  logic [9:0]         x_pixel,
  input  logic [9:0]         y_pixel,
  input  logic [15:0]        camera_pixel,
  input  logic [15:0]        rom_pixel,
  input  logic [SCORE_W-1:0] score,
  input  logic [9:0]         ball_x,
  input  logic [9:0]         ball_y,
  output logic [OFS_W-1:0]   x_offset,
  output logic [OFS_W-1:0]   y_offset,
  output logic [3:0]         red_port,
  output logic [3:0]         green_port,
  output logic [3:0]         blue_port,
  output logic               is_hit_area,
  output logic               hit_frame,
  output logic               bcd_busy
);

  localparam int S  = 1 << SCALE_LOG2;
  localparam int TW = DIGITS * 8 * S;
  localparam int TH = 8 * S;
  localparam int NB0 = SCORE_W / 3 + 1;
  localparam int NB = (NB0 > DIGITS) ? NB0 : DIGITS;
  localparam int CW = $clog2(SCORE_W + 1);
  localparam int unsigned MAXV = 10 ** DIGITS - 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  bcd_state_t state_q, state_d;

  logic [9:0]          bx, by;
  logic [SCORE_W-1:0]  score_lat;
  logic [4*NB-1:0]     bcd_q, adj;
  logic [SCORE_W-1:0]  bin_q;
  logic [CW-1:0]       cnt_q;
  logic [4*DIGITS-1:0] disp_q;
  logic [15:0]         hit_cnt;

  // frame latch: ball position and score are frozen for the whole frame
  always_ff @(posedge clk) begin
    if (reset) begin
      bx        <= '0;
      by        <= '0;
      score_lat <= '0;
    end else if (frame_start) begin
      bx        <= ball_x;
      by        <= ball_y;
      score_lat <= score;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SHIFT:   if (cnt_q == CW'(SCORE_W - 1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (frame_start) state_d = SHIFT;
  end

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < NB; i++)
      if (bcd_q[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_q  <= '0;
      bin_q  <= '0;
      cnt_q  <= '0;
      disp_q <= '0;
    end else if (frame_start) begin
      bcd_q <= '0;
      bin_q <= score;
      cnt_q <= '0;
    end else begin
      case (state_q)
        SHIFT: begin
          {bcd_q, bin_q} <= {adj, bin_q} << 1;
          cnt_q          <= cnt_q + 1'b1;
        end
        DONE: begin
          if (32'(score_lat) > MAXV) disp_q <= {DIGITS{4'd9}};
          else                       disp_q <= bcd_q[4*DIGITS-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bcd_busy = (state_q != IDLE);

  // stage 0: region decode on the incoming coordinate
  logic [9:0]  bdx, bdy;
  logic [10:0] tdx, tdy;
  logic        in_ball0, in_text0, hit0;

  assign bdx      = x_pixel - bx;
  assign bdy      = y_pixel - by;
  assign x_offset = bdx[OFS_W-1:0];
  assign y_offset = bdy[OFS_W-1:0];
  assign in_ball0 = (bdx < 10'(BALL_SIZE)) && (bdy < 10'(BALL_SIZE));
  assign tdx      = {1'b0, x_pixel} - 11'(TEXT_X);
  assign tdy      = {1'b0, y_pixel} - 11'(TEXT_Y);
  assign in_text0 = (tdx < 11'(TW)) && (tdy < 11'(TH));
  assign hit0     = de && in_ball0 &&
                    (camera_pixel[15:11] >= 5'(HIT_RED_MIN));

  always_ff @(posedge clk) begin
    if (reset) begin
      hit_cnt   <= '0;
      hit_frame <= 1'b0;
    end else if (frame_start) begin
      hit_frame <= (hit_cnt >= 16'(HIT_MIN_PIXELS));
      hit_cnt   <= '0;
    end else if (hit0 && hit_cnt != 16'hFFFF) begin
      hit_cnt <= hit_cnt + 16'd1;
    end
  end

  // stage 1
  logic        s1_de, s1_ball, s1_text, s1_hit;
  logic [2:0]  s1_didx, s1_row, s1_col;
  logic [15:0] s1_cam;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_de   <= 1'b0;
      s1_ball <= 1'b0;
      s1_text <= 1'b0;
      s1_hit  <= 1'b0;
      s1_didx <= '0;
      s1_row  <= '0;
      s1_col  <= '0;
      s1_cam  <= '0;
    end else begin
      s1_de   <= de;
      s1_ball <= in_ball0;
      s1_text <= in_text0;
      s1_hit  <= hit0;
      s1_didx <= 3'(tdx >> (3 + SCALE_LOG2));
      s1_row  <= 3'(tdy >> SCALE_LOG2);
      s1_col  <= 3'(tdx >> SCALE_LOG2);
      s1_cam  <= camera_pixel;
    end
  end

  function automatic logic [63:0] font(input logic [3:0] d);
    case (d)
      4'd0:    font = 64'h3C666E7666663C00;
      4'd1:    font = 64'h1838181818187E00;
      4'd2:    font = 64'h3C66060C30607E00;
      4'd3:    font = 64'h3C66061C06663C00;
      4'd4:    font = 64'h0C1C3C6C7E0C0C00;
      4'd5:    font = 64'h7E607C0606663C00;
      4'd6:    font = 64'h3C607C6666663C00;
      4'd7:    font = 64'h7E060C1818181800;
      4'd8:    font = 64'h3C66663C66663C00;
      4'd9:    font = 64'h3C66663E060C3800;
      default: font = 64'h0;
    endcase
  endfunction

  // leading zeros blank until the first non-zero digit; units always shown
  logic [DIGITS-1:0] shown;
  logic              seen;

  always_comb begin
    seen  = 1'b0;
    shown = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen     = seen | (disp_q[4*i +: 4] != 4'd0);
      shown[i] = seen | (i == 0);
    end
  end

  // stage 2: glyph lookup and priority mux
  logic [3:0]  digit;
  logic        shown_sel, lit;
  logic [63:0] glyph;
  logic [7:0]  row_bits;
  logic [15:0] pix;

  always_comb begin
    digit     = '0;
    shown_sel = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      if (s1_didx == 3'(DIGITS - 1 - i)) begin
        digit     = disp_q[4*i +: 4];
        shown_sel = shown[i];
      end
    glyph    = font(digit);
    row_bits = '0;
    for (int r = 0; r < 8; r++)
      if (s1_row == 3'(r)) row_bits = glyph[8*(7-r) +: 8];
    lit = s1_text & shown_sel & row_bits[3'd7 - s1_col];
  end

  always_comb begin
    pix = s1_cam;
    if (!s1_de)                              pix = '0;
    else if (s1_ball && rom_pixel != 16'h0)  pix = rom_pixel;
    else if (lit)                            pix = 16'hFFFF;
    else if (s1_text && TEXT_OPAQUE != 0)    pix = '0;
  end

  logic unused_pix;
  assign unused_pix = ^{pix[11], pix[6:5], pix[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      red_port    <= '0;
      green_port  <= '0;
      blue_port   <= '0;
      is_hit_area <= 1'b0;
    end else begin
      red_port    <= pix[15:12];
      green_port  <= pix[10:7];
      blue_port   <= pix[4:1];
      is_hit_area <= s1_hit;
    end
  end

endmodule

// File: tb/tb_score_ball_compositor.sv
// Directed vector bench for score_ball_compositor: text, ball,
// BCD timing, restart, hit statistics, scaled transparent font.
module tb_score_ball_compositor;

  logic        clk;
  logic        reset, frame_start, de;
  logic [9:0]  x_pixel, y_pixel, ball_x, ball_y, score;
  logic [15:0] camera_pixel, rom1, rom2;
  logic [4:0]  xo1, yo1, xo2, yo2;
  logic [3:0]  r1, g1, b1, r2, g2, b2;
  logic        hit1, hit2, hf1, hf2, busy1, busy2;

  localparam logic [15:0] CAM = 16'h1234;

  score_ball_compositor dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .de(de),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .camera_pixel(camera_pixel),
    .rom_pixel(rom1), .score(score), .ball_x(ball_x), .ball_y(ball_y),
    .x_offset(xo1), .y_offset(yo1), .red_port(r1), .green_port(g1),
    .blue_port(b1), .is_hit_area(hit1), .hit_frame(hf1),
    .bcd_busy(busy1)
  );

  score_ball_compositor #(.SCALE_LOG2(1), .TEXT_OPAQUE(0)) dut2 (
    .clk(clk), .reset(reset), .frame_start(frame_start), .de(de),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .camera_pixel(camera_pixel),
    .rom_pixel(rom2), .score(score), .ball_x(ball_x), .ball_y(ball_y),
    .x_offset(xo2), .y_offset(yo2), .red_port(r2), .green_port(g2),
    .blue_port(b2), .is_hit_area(hit2), .hit_frame(hf2),
    .bcd_busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom_fn(input logic [4:0] xo,
                                         input logic [4:0] yo);
    if ((xo == 5'd0 || xo == 5'd19) && (yo == 5'd0 || yo == 5'd19))
      return 16'h0000;
    return 16'hF800;
  endfunction

  always @(posedge clk) begin
    rom1 <= rom_fn(xo1, yo1);
    rom2 <= rom_fn(xo2, yo2);
  end

  typedef struct {
    int          x;
    int          y;
    logic [15:0] cam;
    logic        d;
    logic [11:0] rgb;
    logic        h;
  } vec_t;

  vec_t vq[$];
  int   total = 0;
  int   passed = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else
      passed++;
  endtask

  function automatic void add(input int x, input int y,
                              input logic [15:0] cam, input logic d,
                              input logic [11:0] rgb, input logic h);
    vec_t v;
    v.x = x; v.y = y; v.cam = cam; v.d = d; v.rgb = rgb; v.h = h;
    vq.push_back(v);
  endfunction

  task automatic check_vec(input vec_t v, input int idx, input bit use2);
    logic [12:0] act;
    act = use2 ? {r2, g2, b2, hit2} : {r1, g1, b1, hit1};
    chk($sformatf("pix%0d(%0d,%0d)", idx, v.x, v.y),
        32'(act), 32'({v.rgb, v.h}));
  endtask

  // streams one pixel per cycle; each result is due two edges later
  task automatic run_vecs(input bit use2);
    for (int i = 0; i < vq.size(); i++) begin
      x_pixel = 10'(vq[i].x);
      y_pixel = 10'(vq[i].y);
      camera_pixel = vq[i].cam;
      de = vq[i].d;
      @(posedge clk); #1;
      if (i > 0) check_vec(vq[i-1], i - 1, use2);
    end
    de = 1'b0; x_pixel = '0; y_pixel = '0;
    @(posedge clk); #1;
    check_vec(vq[vq.size()-1], vq.size() - 1, use2);
    vq.delete();
  endtask

  task automatic new_frame(input int sc, input bit hitpix);
    int n;
    score = 10'(sc);
    de = hitpix; x_pixel = 10'd105; y_pixel = 10'd85;
    camera_pixel = 16'hF800;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0; de = 1'b0;
    n = 0;
    while (busy1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    chk($sformatf("busy_len score=%0d", sc), 32'(n), 32'd11);
  endtask

  task automatic hits(input int n);
    for (int k = 0; k < n; k++) begin
      x_pixel = 10'(100 + k % 20);
      y_pixel = 10'(80 + k / 20);
      camera_pixel = 16'hF800;
      de = 1'b1;
      @(posedge clk); #1;
    end
    de = 1'b0;
  endtask

  initial begin
    int lit, nb;
    reset = 1'b1; frame_start = 1'b0; de = 1'b0;
    x_pixel = '0; y_pixel = '0; camera_pixel = '0;
    score = '0; ball_x = '0; ball_y = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rgb", 32'({r1, g1, b1, hit1}), 32'd0);
    chk("reset_hit_frame", 32'(hf1), 32'd0);
    chk("reset_busy", 32'(busy1), 32'd0);
    reset = 1'b0;

    ball_x = 10'd100; ball_y = 10'd80;
    new_frame(0, 0);
    add(518, 20, CAM, 1, 12'hFFF, 0);
    add(516, 20, CAM, 1, 12'h000, 0);
    add(502, 20, CAM, 1, 12'h000, 0);
    add(510, 20, CAM, 1, 12'h000, 0);
    add(517, 23, CAM, 1, 12'hFFF, 0);
    add(499, 20, CAM, 1, 12'h14A, 0);
    add(518, 28, CAM, 1, 12'h14A, 0);
    add(518, 27, CAM, 1, 12'h000, 0);
    add(518, 20, CAM, 0, 12'h000, 0);
    add(524, 20, CAM, 1, 12'h14A, 0);
    add(500, 19, CAM, 1, 12'h14A, 0);
    add(105, 85, CAM, 1, 12'hF00, 0);
    add(100, 80, CAM, 1, 12'h14A, 0);
    add(119, 99, CAM, 1, 12'h14A, 0);
    add(119, 80, CAM, 1, 12'h14A, 0);
    add(120, 85, CAM, 1, 12'h14A, 0);
    add(99, 85, CAM, 1, 12'h14A, 0);
    add(101, 80, CAM, 1, 12'hF00, 0);
    add(106, 86, 16'hF81F, 1, 12'hF00, 1);
    add(107, 86, 16'hF81F, 0, 12'h000, 0);
    add(110, 90, 16'hA000, 1, 12'hF00, 1);
    add(111, 90, 16'h9800, 1, 12'hF00, 0);
    add(100, 80, 16'hF81F, 1, 12'hF0F, 1);
    run_vecs(0);

    ball_x = 10'd300;
    add(105, 85, CAM, 1, 12'hF00, 0);
    add(305, 85, CAM, 1, 12'h14A, 0);
    run_vecs(0);

    new_frame(7, 0);
    add(517, 20, CAM, 1, 12'hFFF, 0);
    add(516, 20, CAM, 1, 12'h000, 0);
    add(502, 20, CAM, 1, 12'h000, 0);
    add(510, 20, CAM, 1, 12'h000, 0);
    add(305, 85, CAM, 1, 12'hF00, 0);
    add(105, 85, CAM, 1, 12'h14A, 0);
    run_vecs(0);
    ball_x = 10'd100;

    new_frame(1023, 0);
    add(502, 20, CAM, 1, 12'hFFF, 0);
    add(510, 20, CAM, 1, 12'hFFF, 0);
    add(518, 20, CAM, 1, 12'hFFF, 0);
    add(501, 23, CAM, 1, 12'h000, 0);
    add(502, 23, CAM, 1, 12'hFFF, 0);
    run_vecs(0);

    new_frame(123, 0);
    add(503, 20, CAM, 1, 12'hFFF, 0);
    add(502, 20, CAM, 1, 12'h000, 0);
    add(510, 20, CAM, 1, 12'hFFF, 0);
    add(517, 21, CAM, 1, 12'hFFF, 0);
    add(519, 21, CAM, 1, 12'h000, 0);
    run_vecs(0);

    // restart 4 cycles into a 1023 conversion; "999" must never appear
    x_pixel = 10'd502; y_pixel = 10'd23; camera_pixel = CAM; de = 1'b1;
    score = 10'd1023; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    lit = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if ({r1, g1, b1} == 12'hFFF) lit++;
    end
    score = 10'd45; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    nb = 0;
    for (int k = 0; k < 30; k++) begin
      if (busy1) nb++;
      if ({r1, g1, b1} == 12'hFFF) lit++;
      @(posedge clk); #1;
    end
    de = 1'b0;
    chk("restart_busy_len", 32'(nb), 32'd11);
    chk("restart_no_999", 32'(lit), 32'd0);
    add(503, 20, CAM, 1, 12'h000, 0);
    add(512, 20, CAM, 1, 12'hFFF, 0);
    add(517, 20, CAM, 1, 12'hFFF, 0);
    add(522, 22, CAM, 1, 12'h000, 0);
    add(521, 22, CAM, 1, 12'hFFF, 0);
    add(502, 23, CAM, 1, 12'h000, 0);
    run_vecs(0);

    new_frame(8, 0);
    add(536, 20, CAM, 1, 12'hFFF, 0);
    add(537, 21, CAM, 1, 12'hFFF, 0);
    add(535, 20, CAM, 1, 12'h14A, 0);
    add(536, 22, CAM, 1, 12'hFFF, 0);
    add(540, 20, CAM, 1, 12'hFFF, 0);
    add(542, 20, CAM, 1, 12'hFFF, 0);
    add(544, 20, CAM, 1, 12'h14A, 0);
    add(532, 20, CAM, 1, 12'h14A, 0);
    add(536, 34, CAM, 1, 12'h14A, 0);
    add(536, 36, CAM, 1, 12'h14A, 0);
    add(548, 20, CAM, 1, 12'h14A, 0);
    add(504, 20, CAM, 1, 12'h14A, 0);
    run_vecs(1);

    ball_x = 10'd530; ball_y = 10'd15;
    new_frame(8, 0);
    add(536, 20, CAM, 1, 12'hF00, 0);
    add(540, 24, CAM, 1, 12'hF00, 0);
    add(530, 15, CAM, 1, 12'h14A, 0);
    run_vecs(1);

    ball_x = 10'd100; ball_y = 10'd80;
    new_frame(8, 0);
    hits(50);
    new_frame(8, 0);
    chk("hit_frame_50", 32'(hf1), 32'd1);
    hits(39);
    new_frame(8, 1);
    chk("hit_frame_39", 32'(hf1), 32'd0);
    hits(39);
    new_frame(8, 0);
    chk("hit_frame_discard", 32'(hf1), 32'd0);
    hits(40);
    new_frame(8, 0);
    chk("hit_frame_40", 32'(hf1), 32'd1);

    score = 10'd5; frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("reset_abort_busy", 32'(busy1), 32'd0);
    chk("reset_hit_frame2", 32'(hf1), 32'd0);
    add(517, 23, CAM, 1, 12'hFFF, 0);
    add(502, 20, CAM, 1, 12'h000, 0);
    run_vecs(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
